set_assoc_cache_nway: RTL and testbench
=======================================

# set_assoc_cache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines, true-LRU replacement and word-by-word burst refill/write-back. Sits between the CPU load/store port and main memory, keeping the one-request CPU handshake and single-word memory handshake. Generalises the fixed 4-way/256-set single-word cache: adds configurable geometry, multi-word lines, LRU victim choice and correct dirty-line eviction.

## Interface
- WAYS, 4, associativity; power of two, ≥2
- SETS, 256, number of sets; power of two, ≥2
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥1
- clk  in  1  clock
- nrst  in  1  asynchronous, active-low reset
- cpu_op  in  1  1 = read, 0 = write
- cpu_valid  in  1  request valid; op, address and data held stable until cache_ready
- cache_addr  in  32  word-aligned byte address; bits [1:0] ignored
- cpu_write_data  in  32  store data
- cache_ready  out  1  request complete this cycle; low = stall CPU
- cache_data  out  32  load data, valid when cache_ready && cpu_op
- cache_op  out  1  memory op: 1 = read, 0 = write
- cache_valid  out  1  memory beat request
- mem_addr  out  32  beat word address
- cache_write_data  out  32  write-back beat data
- mem_ready  in  1  beat accepted/data returned; ignored while cache_valid low
- mem_data  in  32  refill beat data

## Operation
- Address split: offset [1:0]; word = next log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits.
- Storage per set/way: valid, dirty, tag, LINE_WORDS data words, LRU age (log2(WAYS) bits).
- FSM states: IDLE, WRITE_BACK, REFILL.
- IDLE, hit (valid && tag match): cache_ready=1 same cycle. Read drives selected word on cache_data. Write updates the word and sets dirty. Both update LRU.
- IDLE, miss: victim = lowest-index invalid way, else the way with age WAYS-1. Victim valid && dirty → WRITE_BACK, else → REFILL. Victim way index is latched at the transition.
- WRITE_BACK: LINE_WORDS beats, cache_op=0, mem_addr={victim tag, index, beat, 2'b00}, cache_write_data = victim word[beat]. Beat advances on mem_ready. After the last beat: clear dirty, go to REFILL.
- REFILL: LINE_WORDS beats, cache_op=1, mem_addr={req tag, index, beat, 2'b00}, each mem_data written into victim word[beat]. On the last beat: valid=1, dirty=0, tag=req tag, go to IDLE. The held request then hits on the next cycle.
- LRU update on access to way w with age a: every way in the set with age < a increments; w gets 0. Ages in a set stay a permutation of 0..WAYS-1. Reset ages = way index.
- Outputs when not in use: cache_data=0 unless read hit; cache_valid=0, cache_op=1, mem_addr=0, cache_write_data=0 in IDLE.

## Timing
- Reset (async, immediate): state IDLE, all valid/dirty 0, ages = way index, beat counter 0. cache_ready=0, cache_data=0, cache_valid=0, cache_op=1, mem_addr=0, cache_write_data=0.
- Hit latency: 0 cycles (combinational ready).
- Miss latency: clean miss = LINE_WORDS accepted beats + 1 cycle. Dirty miss adds LINE_WORDS write-back beats.
- cache_valid holds with address/data stable until mem_ready; beats are back-to-back when mem_ready stays high.
- cpu_valid dropping mid-miss: the burst still completes and the line is installed; no abort.
- Reset mid-burst: the burst is abandoned, cache_valid drops asynchronously, and the partial line is never marked valid.
- cache_ready is never asserted outside IDLE.

## Structure
- Package cache_pkg: state enum, address-field width functions (clog2-based), and a line struct (valid, dirty, tag, words).
- Sub-module cache_lru: per-set age update and victim select, parametrised by WAYS.

## Test plan
Defaults; 0x1000/0x2000/0x3000/0x4000/0x5000 all map to index 0 with tags 1–5.
- Reset, then read 0x1000 → cache_valid/cache_op=1 beats at 0x1000,0x1004,0x1008,0x100C. Memory returns 0xA0..0xA3; one cycle after the last beat, cache_ready=1 with cache_data=0xA0.
- Read 0x1008 after that fill → cache_ready=1 in the same cycle, cache_data=0xA2, no memory activity.
- Write 0xDEAD to 0x1004, fill tags 2–4, then read 0x5000 → way 0 (LRU) written back: 4 write beats at 0x1000–0x100C, second beat data 0xDEAD; then refill at 0x5000.
- Access order 0x1000,0x2000,0x3000,0x4000,0x1000, then miss 0x5000 → evicts tag 2's way, not tag 1's.
- Hold mem_ready low 5 cycles on beat 1 → cache_valid and mem_addr stay stable; the beat counter does not advance.
- Assert nrst low on refill beat 2 → cache_valid=0 immediately; a later read of 0x1000 misses and refills fully.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the set-associative cache.
package cache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    REFILL     = 2'd2
  } state_t;

  // Width of an address field selecting one of n items (0 when n == 1).
  function automatic int unsigned field_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Width of a counter/index register for n items (never narrower than 1 bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bookkeeping for one line; the data words live in a separate word-addressed array.
  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-1:0] tag;
  } line_meta_t;

endpackage

// File: rtl/cache_lru.sv
// True-LRU age update and victim selection for one set.
module cache_lru
  import cache_pkg::*;
#(
  parameter int unsigned WAYS = 4,
  localparam int unsigned AW  = cnt_w(WAYS)
) (
  input  logic [WAYS*AW-1:0] ages,
  input  logic [WAYS-1:0]    valid,
  input  logic [AW-1:0]      access_way,
  output logic [AW-1:0]      victim,
  output logic [WAYS*AW-1:0] ages_next
);

  logic [AW-1:0] access_age;

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[w*AW +: AW] == AW'(WAYS - 1)) victim = AW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = AW'(w);
    end
  end

  // Accessed way becomes youngest; ways younger than it age by one.
  always_comb begin
    access_age = '0;
    ages_next  = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == access_way) access_age = ages[w*AW +: AW];
    end
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == access_way) begin
        ages_next[w*AW +: AW] = '0;
      end else if (ages[w*AW +: AW] < access_age) begin
        ages_next[w*AW +: AW] = ages[w*AW +: AW] + AW'(1);
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache_nway.sv
// N-way set-associative write-back/write-allocate cache with burst refill and write-back.
module set_assoc_cache_nway
  import cache_pkg::*;
#(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 256,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpu_op,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic              cache_ready,
  output logic [DATA_W-1:0] cache_data,
  output logic              cache_op,
  output logic              cache_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] cache_write_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int unsigned AW     = cnt_w(WAYS);
  localparam int unsigned IW     = cnt_w(SETS);
  localparam int unsigned BW     = cnt_w(LINE_WORDS);
  localparam int unsigned LNW    = IW + AW;
  localparam int unsigned DW     = LNW + field_w(LINE_WORDS);
  localparam int unsigned IDX_SH = 2 + field_w(LINE_WORDS);
  localparam int unsigned TAG_SH = IDX_SH + field_w(SETS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  line_meta_t        meta_q [SETS*WAYS];
  logic [AW-1:0]     age_q  [SETS*WAYS];
  logic [DATA_W-1:0] data_q [SETS*WAYS*LINE_WORDS];

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [AW-1:0]     victim_q, victim_d;
  logic [IW-1:0]     miss_index_q, miss_index_d;
  logic [ADDR_W-1:0] miss_tag_q, miss_tag_d;

  logic [BW-1:0]      req_word;
  logic [IW-1:0]      req_index;
  logic [ADDR_W-1:0]  req_tag;
  logic [WAYS-1:0]    set_valid, hit_vec;
  logic [WAYS*AW-1:0] set_ages, lru_ages_next;
  logic [AW-1:0]      hit_way, lru_victim;
  logic               hit;

  logic              data_we, meta_we, lru_we;
  logic [DW-1:0]     data_waddr;
  logic [DATA_W-1:0] data_wdata;
  logic [LNW-1:0]    meta_waddr;
  line_meta_t        meta_wdata, vmeta;

  function automatic logic [LNW-1:0] line_at(input logic [IW-1:0] idx, input logic [AW-1:0] way);
    return {idx, way};
  endfunction

  function automatic logic [DW-1:0] word_at(input logic [IW-1:0] idx, input logic [AW-1:0] way,
                                            input logic [BW-1:0] word);
    return DW'((ADDR_W'(line_at(idx, way)) << field_w(LINE_WORDS)) | ADDR_W'(word));
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] tag,
                                                  input logic [IW-1:0] idx, input logic [BW-1:0] beat);
    return (tag << TAG_SH) | (ADDR_W'(idx) << IDX_SH) | (ADDR_W'(beat) << 2);
  endfunction

  assign req_word  = BW'((cache_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
  assign req_index = IW'(cache_addr >> IDX_SH);
  assign req_tag   = cache_addr >> TAG_SH;
  assign hit       = |hit_vec;

  // Look up every way of the requested set.
  always_comb begin
    set_valid = '0;
    hit_vec   = '0;
    set_ages  = '0;
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w]          = meta_q[line_at(req_index, AW'(w))].valid;
      hit_vec[w]            = set_valid[w] && (meta_q[line_at(req_index, AW'(w))].tag == req_tag);
      set_ages[w*AW +: AW]  = age_q[line_at(req_index, AW'(w))];
      if (hit_vec[w]) hit_way = AW'(w);
    end
  end

  cache_lru #(.WAYS(WAYS)) u_lru (
    .ages       (set_ages),
    .valid      (set_valid),
    .access_way (hit_way),
    .victim     (lru_victim),
    .ages_next  (lru_ages_next)
  );

  // Controller state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      victim_q     <= '0;
      miss_index_q <= '0;
      miss_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      victim_q     <= victim_d;
      miss_index_q <= miss_index_d;
      miss_tag_q   <= miss_tag_d;
    end
  end

  // Next state, CPU/memory handshakes and storage write controls.
  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    victim_d         = victim_q;
    miss_index_d     = miss_index_q;
    miss_tag_d       = miss_tag_q;
    cache_ready      = 1'b0;
    cache_data       = '0;
    cache_valid      = 1'b0;
    cache_op         = 1'b1;
    mem_addr         = '0;
    cache_write_data = '0;
    data_we          = 1'b0;
    data_waddr       = word_at(miss_index_q, victim_q, beat_q);
    data_wdata       = mem_data;
    meta_we          = 1'b0;
    meta_waddr       = line_at(miss_index_q, victim_q);
    vmeta            = meta_q[line_at(miss_index_q, victim_q)];
    meta_wdata       = vmeta;
    lru_we           = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          if (hit) begin
            cache_ready = 1'b1;
            lru_we      = 1'b1;
            if (cpu_op) begin
              cache_data = data_q[word_at(req_index, hit_way, req_word)];
            end else begin
              data_we          = 1'b1;
              data_waddr       = word_at(req_index, hit_way, req_word);
              data_wdata       = cpu_write_data;
              meta_we          = 1'b1;
              meta_waddr       = line_at(req_index, hit_way);
              meta_wdata       = meta_q[line_at(req_index, hit_way)];
              meta_wdata.dirty = 1'b1;
            end
          end else begin
            vmeta        = meta_q[line_at(req_index, lru_victim)];
            victim_d     = lru_victim;
            miss_index_d = req_index;
            miss_tag_d   = req_tag;
            beat_d       = '0;
            state_d      = (vmeta.valid && vmeta.dirty) ? WRITE_BACK : REFILL;
          end
        end
      end
      WRITE_BACK: begin
        cache_valid      = 1'b1;
        cache_op         = 1'b0;
        mem_addr         = beat_addr(vmeta.tag, miss_index_q, beat_q);
        cache_write_data = data_q[word_at(miss_index_q, victim_q, beat_q)];
        if (mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d           = '0;
            state_d          = REFILL;
            meta_we          = 1'b1;
            meta_wdata.dirty = 1'b0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      REFILL: begin
        cache_valid = 1'b1;
        cache_op    = 1'b1;
        mem_addr    = beat_addr(miss_tag_q, miss_index_q, beat_q);
        if (mem_ready) begin
          data_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d     = '0;
            state_d    = IDLE;
            meta_we    = 1'b1;
            meta_wdata = '{valid: 1'b1, dirty: 1'b0, tag: miss_tag_q};
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line bookkeeping and LRU ages; reset invalidates all lines and restores age order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < SETS*WAYS; i++) begin
        meta_q[LNW'(i)] <= '0;
        age_q[LNW'(i)]  <= AW'(i % WAYS);
      end
    end else begin
      if (meta_we) meta_q[meta_waddr] <= meta_wdata;
      if (lru_we) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[line_at(req_index, AW'(w))] <= lru_ages_next[w*AW +: AW];
        end
      end
    end
  end

  // Data words: refill beats and store hits.
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_waddr] <= data_wdata;
  end

endmodule

// File: tb/tb_set_assoc_cache_nway.sv
// Directed bench for set_assoc_cache_nway with a scripted memory responder and beat scoreboard.
module tb_set_assoc_cache_nway;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cpu_op, cpu_valid;
  logic [31:0] cache_addr, cpu_write_data;
  logic        cache_ready;
  logic [31:0] cache_data;
  logic        cache_op, cache_valid;
  logic [31:0] mem_addr, cache_write_data;
  logic        mem_ready;
  logic [31:0] mem_data;

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] gold_m [int unsigned];
  logic [31:0] mem_m  [int unsigned];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          beat_no  = 0;
  int          stall_beat = -1;
  int          stall_left = 0;

  set_assoc_cache_nway #(.WAYS(4), .SETS(256), .LINE_WORDS(4)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .cpu_op           (cpu_op),
    .cpu_valid        (cpu_valid),
    .cache_addr       (cache_addr),
    .cpu_write_data   (cpu_write_data),
    .cache_ready      (cache_ready),
    .cache_data       (cache_data),
    .cache_op         (cache_op),
    .cache_valid      (cache_valid),
    .mem_addr         (mem_addr),
    .cache_write_data (cache_write_data),
    .mem_ready        (mem_ready),
    .mem_data         (mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a[31:12] == 20'h00001) return 32'h0000_00A0 + {30'd0, a[3:2]};
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold_m.exists(a) ? gold_m[a] : init_val(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Queue the four beats a line transfer should produce.
  task automatic expect_line(input logic op, input logic [31:0] base);
    for (int b = 0; b < 4; b++) begin
      beat_t e;
      e.op   = op;
      e.addr = base + 32'(b * 4);
      e.data = op ? 32'd0 : gold_rd(e.addr);
      exp_q.push_back(e);
    end
  endtask

  // Issue one CPU request, wait for ready within a bound, check latency and load data.
  task automatic cpu_req(input string tag, input logic op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_cycles);
    int cycles;
    @(negedge clk);
    cpu_op = op; cache_addr = addr; cpu_write_data = wdata; cpu_valid = 1'b1;
    #1;
    cycles = 0;
    while (!cache_ready && cycles < 200) begin
      @(negedge clk); #1;
      cycles++;
    end
    chk({tag, "_ready"}, 32'(cache_ready), 32'd1);
    chk({tag, "_latency"}, cycles, exp_cycles);
    if (op) chk({tag, "_data"}, cache_data, gold_rd(addr));
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    if (!op) gold_m[addr] = wdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; cpu_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  // Memory responder: checks each presented beat against the scoreboard and answers it.
  initial begin
    mem_ready = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk);
      if (!nrst || !cache_valid) begin
        mem_ready = 1'b0;
        beat_no   = 0;
      end else if (stall_left > 0 && beat_no == stall_beat) begin
        mem_ready = 1'b0;
        stall_left--;
        chk("stall_addr", mem_addr, (exp_q.size() > 0) ? exp_q[0].addr : 32'hFFFF_FFFF);
        chk("stall_op", 32'(cache_op), 32'd1);
      end else begin
        chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        mem_data = '0;
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_op", 32'(cache_op), 32'(e.op));
          chk("beat_addr", mem_addr, e.addr);
          if (!e.op) chk("wb_data", cache_write_data, e.data);
        end
        if (cache_op) mem_data = mem_rd(mem_addr);
        else mem_m[mem_addr] = cache_write_data;
        mem_ready = 1'b1;
        beat_no++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int waited;
    nrst = 1'b0; cpu_valid = 1'b0; cpu_op = 1'b1;
    cache_addr = '0; cpu_write_data = '0;
    #1;
    chk("rst_ready", 32'(cache_ready), 32'd0);
    chk("rst_data", cache_data, 32'd0);
    chk("rst_valid", 32'(cache_valid), 32'd0);
    chk("rst_op", 32'(cache_op), 32'd1);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", cache_write_data, 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // Cold read miss then hits in the same line.
    expect_line(1'b1, 32'h1000);
    cpu_req("rd_1000", 1'b1, 32'h1000, 32'd0, 5);
    chk("fill_q_empty", exp_q.size(), 0);
    cpu_req("rd_1008", 1'b1, 32'h1008, 32'd0, 0);
    cpu_req("wr_1004", 1'b0, 32'h1004, 32'h0000_DEAD, 0);
    cpu_req("rd_1004", 1'b1, 32'h1004, 32'd0, 0);

    // Fill the other ways, then evict the dirty LRU line.
    for (int t = 2; t <= 4; t++) begin
      expect_line(1'b1, 32'(t) << 12);
      cpu_req("fill_way", 1'b1, 32'(t) << 12, 32'd0, 5);
    end
    expect_line(1'b0, 32'h1000);
    expect_line(1'b1, 32'h5000);
    cpu_req("dirty_evict", 1'b1, 32'h5000, 32'd0, 9);
    chk("evict_q_empty", exp_q.size(), 0);

    // LRU order: re-touching tag 1 makes tag 2 the victim.
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      expect_line(1'b1, 32'(t) << 12);
      cpu_req("lru_fill", 1'b1, 32'(t) << 12, 32'd0, 5);
    end
    cpu_req("lru_touch1", 1'b1, 32'h1000, 32'd0, 0);
    expect_line(1'b1, 32'h5000);
    cpu_req("lru_miss5", 1'b1, 32'h5000, 32'd0, 5);
    cpu_req("lru_keep1", 1'b1, 32'h1000, 32'd0, 0);
    expect_line(1'b1, 32'h2000);
    cpu_req("lru_gone2", 1'b1, 32'h2000, 32'd0, 5);

    // Memory stall on beat 1.
    stall_beat = 1; stall_left = 5;
    expect_line(1'b1, 32'h6000);
    cpu_req("stall_fill", 1'b1, 32'h6000, 32'd0, 10);
    chk("stall_consumed", stall_left, 0);
    stall_beat = -1;

    // Reset during refill beat 2 abandons the burst.
    expect_line(1'b1, 32'h7000);
    @(negedge clk);
    cpu_op = 1'b1; cache_addr = 32'h7000; cpu_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk); #2;
      waited++;
    end while (!(cache_valid && mem_addr == 32'h7008) && waited < 50);
    chk("rst_mid_reached", mem_addr, 32'h7008);
    nrst = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(cache_valid), 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_ready", 32'(cache_ready), 32'd0);
    cpu_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    expect_line(1'b1, 32'h1000);
    cpu_req("post_rst_1000", 1'b1, 32'h1000, 32'd0, 5);
    expect_line(1'b1, 32'h7000);
    cpu_req("post_rst_7000", 1'b1, 32'h7000, 32'd0, 5);

    chk("final_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
